dsi_ppi_rx: RTL
===============

# dsi_ppi_rx

Receive-side DSI packet engine: takes the 4-lane PPI byte stream (lane0..lane3 bytes per pclk beat) and splits it into packets. It checks and optionally corrects the header ECC, then emits short-packet events and long-packet payload words, and checks the payload CRC-16. It is the loopback and peripheral-model counterpart of the `dsi` transmit path and sits directly on its `ppi_data_lane*` / `ppi_lane*_en` outputs.

## Interface
- `MAX_WC`, 16'hFFFF: largest accepted word count; larger WC is treated as a header error.
- `pclk` in 1: core clock; all logic on rising edge.
- `dsi_rst` in 1: reset, asynchronous, active-low; clock `pclk`.
- `ppi_data_lane0..3` in 8 each: lane bytes; lane0 is the lowest byte of each beat.
- `ppi_lane0_en..3_en` in 1 each: lane valid; a beat is valid only when all four are high.
- `sp_valid` out 1: pulse; a short packet was accepted.
- `sp_dt` out 6: short-packet data type (DI[5:0]).
- `sp_vc` out 2: virtual channel (DI[7:6]); also valid with `rx_first`.
- `sp_data` out 16: short-packet data {byte2, byte1}.
- `rx_valid` out 1: payload beat valid.
- `rx_data` out 32: payload bytes, lane order.
- `rx_be` out 4: payload byte enables. Contiguous from bit 0. CRC and pad bytes are never enabled.
- `rx_first`, `rx_last` out 1 each: first and last payload beat of a long packet.
- `rx_dt` out 6: data type of the current long packet.
- `pkt_done` out 1: pulse at the end of every packet, short or long.
- `ecc_corr`, `ecc_err`, `crc_err`, `lane_err` out 1 each: status; valid with `pkt_done`.
- `err_cnt` out 8: saturating count of packets with `ecc_err`, `crc_err` or `lane_err`.

## Operation
- FSM states: HDR, PAYLOAD, CRC_HI.
- HDR:
  - Each valid beat is a header: {ECC, WC_hi, WC_lo, DI} = {lane3..lane0}.
  - The 6-bit DSI Hamming syndrome is computed over the 24 bits {WC_hi, WC_lo, DI}. ECC[7:6] must be 0, otherwise the header is uncorrectable.
- Syndrome handling:
  - Syndrome 0: header good.
  - Single-bit syndrome: handled per Configuration.
  - Any other syndrome: `ecc_err`; the packet is dropped. `pkt_done` pulses and the FSM stays in HDR; no payload is consumed.
- Packet type:
  - Long packet iff DT ∈ {0x29, 0x39, 0x3E}. Everything else is short.
  - Short packet: `sp_valid` and `pkt_done` pulse together; stay in HDR.
  - Long packet: load the 17-bit remaining-byte count `rem = WC+2`, set the CRC to 0xFFFF, and go to PAYLOAD.
- PAYLOAD, per valid beat:
  - Payload bytes in the beat = min(4, rem−2, clamped ≥0). The bytes after those are CRC bytes: low byte first, then high byte.
  - CRC-16 uses the reflected 0x8408 polynomial, init 0xFFFF, no final XOR. It is updated bytewise over the enabled payload bytes, up to 4 bytes unrolled per cycle.
  - `rx_valid` is asserted only when at least 1 payload byte is present. `rx_first` is set on the first such beat. `rx_last` is set on the beat carrying the last payload byte.
  - If both CRC bytes are in the beat: compare, pulse `pkt_done`, go to HDR. Bytes left over after CRC_hi are padding and are discarded.
  - If only CRC_lo is in the beat: latch it and go to CRC_HI.
  - `rem` decrements by the number of bytes consumed.
- CRC_HI: the next valid beat's lane0 is CRC_hi. Compare, pulse `pkt_done`, go to HDR.
- WC = 0: no `rx_valid`; the CRC must equal 0xFFFF.
- Lane error:
  - Trigger: any lane enable low while others are high, in any state; or all enables dropping while in PAYLOAD or CRC_HI.
  - Response: `lane_err` and `pkt_done` pulse, the packet is aborted, go to HDR.
  - In HDR with all enables low there is no error; the receiver is simply idle.
- `err_cnt` increments once per failing packet and saturates at 0xFF.

## Timing
- All outputs are registered, 1 cycle after the beat that caused them.
- Reset (async assert, sync release): FSM = HDR; `rem` = 0; CRC = 0xFFFF; `err_cnt` = 0; every output = 0.
- Reset during PAYLOAD drops the packet with no `pkt_done`.
- No backpressure: the consumer must accept every `rx_valid` beat.
- Back-to-back packets: a header may arrive on the beat immediately after `pkt_done`'s causing beat, with zero bubble.
- `lane_err` on the same beat as a CRC completion: `lane_err` wins and the CRC result is suppressed.

## Configuration
- `DSI_RX_ECC_CORRECT_EN` defined:
  - A single-bit syndrome flips the indicated header bit (or accepts the header if the error is in the ECC byte).
  - Sets `ecc_corr`; the packet proceeds normally.
- Not defined: every nonzero syndrome is `ecc_err` and the packet is dropped. `ecc_corr` is tied to 0.

## Test plan
- Beat {0x07, 0x00, 0x00, 0x01} → `sp_valid`, `sp_dt`=0x01, `sp_vc`=0, `sp_data`=0x0000, `pkt_done`, no error flags.
- Header DI=0x39, WC=0 with correct ECC, then beat {xx, xx, 0xFF, 0xFF} → no `rx_valid`, `pkt_done`, `crc_err`=0. With CRC bytes 0xFF, 0xFE instead → `crc_err`=1, `err_cnt`=1.
- DI=0x3E, WC=3, payload 0xAA 0xBB 0xCC, CRC split across beats → beat 1: `rx_be`=4'b0111, `rx_first`=`rx_last`=1. FSM passes through CRC_HI; `pkt_done` follows the next beat with `crc_err` matching the model CRC.
- Header 0x21, 0x00, 0x00 with ECC 0x12 XOR 0x01 → with the macro: `sp_dt`=0x21, `ecc_corr`=1. Without the macro: `ecc_err`=1 and no `sp_valid`.
- WC=8 long packet with `ppi_lane2_en` low on the 2nd payload beat → `lane_err`, `pkt_done`. The next full header beat is parsed normally.
- `dsi_rst` low mid-payload → all outputs 0 immediately. After release, a short packet (0x01, ECC 0x07) is received correctly.

Source files
------------

// File: rtl/dsi_ppi_rx_if.sv
// dsi_ppi_rx_if: bundle between a 4-lane PPI byte source and the DSI receive
// packet engine.
//   PPI side   : ppi_data_lane0..3 (lane0 = lowest byte), ppi_lane0_en..3_en
//   Short pkts : sp_valid, sp_dt, sp_vc, sp_data
//   Long pkts  : rx_valid, rx_data, rx_be, rx_first, rx_last, rx_dt
//   Status     : pkt_done, ecc_corr, ecc_err, crc_err, lane_err, err_cnt
// master drives the PPI lanes and consumes packet output; slave is the receiver.
interface dsi_ppi_rx_if;
   logic [7:0]  ppi_data_lane0;
   logic [7:0]  ppi_data_lane1;
   logic [7:0]  ppi_data_lane2;
   logic [7:0]  ppi_data_lane3;
   logic        ppi_lane0_en;
   logic        ppi_lane1_en;
   logic        ppi_lane2_en;
   logic        ppi_lane3_en;

   logic        sp_valid;
   logic [5:0]  sp_dt;
   logic [1:0]  sp_vc;
   logic [15:0] sp_data;

   logic        rx_valid;
   logic [31:0] rx_data;
   logic [3:0]  rx_be;
   logic        rx_first;
   logic        rx_last;
   logic [5:0]  rx_dt;

   logic        pkt_done;
   logic        ecc_corr;
   logic        ecc_err;
   logic        crc_err;
   logic        lane_err;
   logic [7:0]  err_cnt;

   modport master (
      output ppi_data_lane0, ppi_data_lane1, ppi_data_lane2, ppi_data_lane3,
      output ppi_lane0_en, ppi_lane1_en, ppi_lane2_en, ppi_lane3_en,
      input  sp_valid, sp_dt, sp_vc, sp_data,
      input  rx_valid, rx_data, rx_be, rx_first, rx_last, rx_dt,
      input  pkt_done, ecc_corr, ecc_err, crc_err, lane_err, err_cnt
   );

   modport slave (
      input  ppi_data_lane0, ppi_data_lane1, ppi_data_lane2, ppi_data_lane3,
      input  ppi_lane0_en, ppi_lane1_en, ppi_lane2_en, ppi_lane3_en,
      output sp_valid, sp_dt, sp_vc, sp_data,
      output rx_valid, rx_data, rx_be, rx_first, rx_last, rx_dt,
      output pkt_done, ecc_corr, ecc_err, crc_err, lane_err, err_cnt
   );
endinterface

// File: rtl/dsi_ppi_rx.sv
// dsi_ppi_rx: receive-side DSI packet engine on a 4-lane PPI byte stream.
// Splits beats into packets, checks the header ECC, emits short-packet events
// and long-packet payload words, and checks the payload CRC-16 (0x8408, init
// 0xFFFF). All outputs are registered one cycle after the causing beat.
// Optional feature: define DSI_RX_ECC_CORRECT_EN to correct single-bit header
// errors (ecc_corr); otherwise any nonzero syndrome drops the packet.
// Ports:
//   pclk     core clock, rising edge
//   dsi_rst  asynchronous active-low reset
//   bus      dsi_ppi_rx_if.slave (PPI lanes in, packet/status outputs out)
// Parameter: MAX_WC, largest accepted long-packet word count.
module dsi_ppi_rx #(
   parameter logic [15:0] MAX_WC = 16'hFFFF
) (
   input logic         pclk,
   input logic         dsi_rst,
   dsi_ppi_rx_if.slave bus
);

   typedef enum logic [1:0] {HDR, PAYLOAD, CRC_HI} state_t;

   typedef struct packed {
      logic        sp_valid;
      logic [5:0]  sp_dt;
      logic [1:0]  sp_vc;
      logic [15:0] sp_data;
      logic        rx_valid;
      logic [31:0] rx_data;
      logic [3:0]  rx_be;
      logic        rx_first;
      logic        rx_last;
      logic [5:0]  rx_dt;
      logic        pkt_done;
      logic        ecc_corr;
      logic        ecc_err;
      logic        crc_err;
      logic        lane_err;
   } out_t;

   // DSI Hamming parity over {WC_hi, WC_lo, DI}
   function automatic logic [5:0] ecc_parity(input logic [23:0] d);
      logic [5:0] p;
      p[0] = ^(d & 24'hF12CB7);
      p[1] = ^(d & 24'hF2555B);
      p[2] = ^(d & 24'h749A6D);
      p[3] = ^(d & 24'hB8E38E);
      p[4] = ^(d & 24'hDF03F0);
      p[5] = ^(d & 24'hEFFC00);
      return p;
   endfunction

   function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      r = c ^ {8'h00, b};
      for (int unsigned i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
      return r;
   endfunction

   state_t      state, state_n;
   logic [16:0] rem, rem_n;
   logic [15:0] crc, crc_n;
   logic [7:0]  crc_lo, crc_lo_n;
   logic        first_pend, first_n;
   logic        corr_pend, corr_n;
   logic [7:0]  err_cnt, err_cnt_n;
   out_t        out_r, out_n;

   logic [31:0] beat;
   logic        en_all, en_any;
   logic [23:0] hdr_fix;
   logic [5:0]  syn;
   logic        hdr_corr, hdr_ok, hdr_long;
   logic [5:0]  hdr_dt;
   logic [15:0] hdr_wc;
   logic [3:0]  pay_be;
   logic [15:0] crc_upd;
   logic [15:0] rx_crc;
   logic        fail;

   assign beat   = {bus.ppi_data_lane3, bus.ppi_data_lane2, bus.ppi_data_lane1, bus.ppi_data_lane0};
   assign en_all = bus.ppi_lane0_en & bus.ppi_lane1_en & bus.ppi_lane2_en & bus.ppi_lane3_en;
   assign en_any = bus.ppi_lane0_en | bus.ppi_lane1_en | bus.ppi_lane2_en | bus.ppi_lane3_en;

   always_comb begin : hdr_check
      syn      = ecc_parity(beat[23:0]) ^ beat[29:24];
      hdr_fix  = beat[23:0];
      hdr_corr = 1'b0;
`ifdef DSI_RX_ECC_CORRECT_EN
      // one-hot syndrome: error sits in the ECC byte, header data is intact
      if ($onehot(syn))
         hdr_corr = 1'b1;
      for (int unsigned j = 0; j < 24; j++) begin
         if (syn == ecc_parity(24'd1 << j)) begin
            hdr_fix  = beat[23:0] ^ (24'd1 << j);
            hdr_corr = 1'b1;
         end
      end
`endif
      hdr_ok   = (beat[31:30] == 2'b00) && ((syn == 6'd0) || hdr_corr);
      hdr_dt   = hdr_fix[5:0];
      hdr_wc   = hdr_fix[23:8];
      hdr_long = (hdr_dt == 6'h29) || (hdr_dt == 6'h39) || (hdr_dt == 6'h3E);
   end

   // rem counts payload + CRC bytes still due; payload occupies the low lanes
   always_comb begin : payload_math
      if (rem >= 17'd6)      pay_be = 4'hF;
      else if (rem == 17'd5) pay_be = 4'h7;
      else if (rem == 17'd4) pay_be = 4'h3;
      else if (rem == 17'd3) pay_be = 4'h1;
      else                   pay_be = 4'h0;

      crc_upd = crc;
      if (pay_be[0]) crc_upd = crc_byte(crc_upd, beat[7:0]);
      if (pay_be[1]) crc_upd = crc_byte(crc_upd, beat[15:8]);
      if (pay_be[2]) crc_upd = crc_byte(crc_upd, beat[23:16]);
      if (pay_be[3]) crc_upd = crc_byte(crc_upd, beat[31:24]);

      if (rem == 17'd4)      rx_crc = beat[31:16];
      else if (rem == 17'd3) rx_crc = beat[23:8];
      else                   rx_crc = beat[15:0];
   end

   always_comb begin : fsm_next
      state_n  = state;
      rem_n    = rem;
      crc_n    = crc;
      crc_lo_n = crc_lo;
      first_n  = first_pend;
      corr_n   = corr_pend;
      fail     = 1'b0;

      out_n          = out_r;
      out_n.sp_valid = 1'b0;
      out_n.rx_valid = 1'b0;
      out_n.rx_data  = '0;
      out_n.rx_be    = '0;
      out_n.rx_first = 1'b0;
      out_n.rx_last  = 1'b0;
      out_n.pkt_done = 1'b0;
      out_n.ecc_corr = 1'b0;
      out_n.ecc_err  = 1'b0;
      out_n.crc_err  = 1'b0;
      out_n.lane_err = 1'b0;

      unique case (state)
         HDR: begin
            if (en_any && !en_all) begin
               out_n.lane_err = 1'b1;
               out_n.pkt_done = 1'b1;
               fail           = 1'b1;
            end else if (en_all) begin
               if (!hdr_ok || (hdr_long && ({1'b0, hdr_wc} > {1'b0, MAX_WC}))) begin
                  out_n.ecc_err  = 1'b1;
                  out_n.pkt_done = 1'b1;
                  fail           = 1'b1;
               end else if (hdr_long) begin
                  state_n     = PAYLOAD;
                  rem_n       = {1'b0, hdr_wc} + 17'd2;
                  crc_n       = '1;
                  first_n     = 1'b1;
                  corr_n      = hdr_corr;
                  out_n.rx_dt = hdr_dt;
                  out_n.sp_vc = hdr_fix[7:6];
               end else begin
                  out_n.sp_valid = 1'b1;
                  out_n.sp_dt    = hdr_dt;
                  out_n.sp_vc    = hdr_fix[7:6];
                  out_n.sp_data  = hdr_wc;
                  out_n.pkt_done = 1'b1;
                  out_n.ecc_corr = hdr_corr;
               end
            end
         end

         PAYLOAD: begin
            if (!en_all) begin
               out_n.lane_err = 1'b1;
               out_n.pkt_done = 1'b1;
               out_n.ecc_corr = corr_pend;
               fail           = 1'b1;
               state_n        = HDR;
            end else begin
               out_n.rx_valid = |pay_be;
               out_n.rx_be    = pay_be;
               out_n.rx_data  = beat & {{8{pay_be[3]}}, {8{pay_be[2]}}, {8{pay_be[1]}}, {8{pay_be[0]}}};
               out_n.rx_first = first_pend & (|pay_be);
               out_n.rx_last  = (|pay_be) && (rem <= 17'd6);
               if (|pay_be)
                  first_n = 1'b0;
               if (rem <= 17'd4) begin
                  // both CRC bytes present; remaining lanes are padding
                  out_n.crc_err  = (rx_crc != crc_upd);
                  out_n.pkt_done = 1'b1;
                  out_n.ecc_corr = corr_pend;
                  fail           = (rx_crc != crc_upd);
                  state_n        = HDR;
               end else begin
                  crc_n = crc_upd;
                  rem_n = rem - 17'd4;
                  if (rem == 17'd5) begin
                     crc_lo_n = beat[31:24];
                     state_n  = CRC_HI;
                  end
               end
            end
         end

         CRC_HI: begin
            out_n.pkt_done = 1'b1;
            out_n.ecc_corr = corr_pend;
            state_n        = HDR;
            if (!en_all) begin
               out_n.lane_err = 1'b1;
               fail           = 1'b1;
            end else begin
               out_n.crc_err = ({beat[7:0], crc_lo} != crc);
               fail          = ({beat[7:0], crc_lo} != crc);
            end
         end

         default: state_n = HDR;
      endcase

      err_cnt_n = (fail && (err_cnt != 8'hFF)) ? err_cnt + 8'd1 : err_cnt;
   end

   always_ff @(posedge pclk or negedge dsi_rst) begin
      if (!dsi_rst) begin
         state      <= HDR;
         rem        <= '0;
         crc        <= '1;
         crc_lo     <= '0;
         first_pend <= 1'b0;
         corr_pend  <= 1'b0;
         err_cnt    <= '0;
         out_r      <= '0;
      end else begin
         state      <= state_n;
         rem        <= rem_n;
         crc        <= crc_n;
         crc_lo     <= crc_lo_n;
         first_pend <= first_n;
         corr_pend  <= corr_n;
         err_cnt    <= err_cnt_n;
         out_r      <= out_n;
      end
   end

   assign bus.sp_valid = out_r.sp_valid;
   assign bus.sp_dt    = out_r.sp_dt;
   assign bus.sp_vc    = out_r.sp_vc;
   assign bus.sp_data  = out_r.sp_data;
   assign bus.rx_valid = out_r.rx_valid;
   assign bus.rx_data  = out_r.rx_data;
   assign bus.rx_be    = out_r.rx_be;
   assign bus.rx_first = out_r.rx_first;
   assign bus.rx_last  = out_r.rx_last;
   assign bus.rx_dt    = out_r.rx_dt;
   assign bus.pkt_done = out_r.pkt_done;
   assign bus.ecc_corr = out_r.ecc_corr;
   assign bus.ecc_err  = out_r.ecc_err;
   assign bus.crc_err  = out_r.crc_err;
   assign bus.lane_err = out_r.lane_err;
   assign bus.err_cnt  = err_cnt;

endmodule
